conv_window_gen: RTL
====================

# conv_window_gen

Streaming 3x3 window generator with binary-weight gating; sits directly upstream of the threshold neuron. It accepts a raster-order pixel stream of 12-bit fixed-point values and buffers two image lines. For every valid (unpadded) 3x3 position it presents nine weight-gated values plus a valid strobe, ready to feed the neuron's nine `input_array_*` inputs.

## Interface
- `DATA_W`, 12, pixel/output width (two's complement fixed point)
- `IMG_W`, 28, image width in pixels (>= 3)
- `IMG_H`, 28, image height in lines (>= 3)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `pix_in`  in  DATA_W  pixel data
- `pix_valid`  in  1  `pix_in` accepted this cycle; no backpressure
- `weight_in`  in  9  binary weights; bit k gates window element k
- `weight_load`  in  1  load `weight_in` into the weight register
- `win_0` … `win_8`  out  DATA_W each  gated window, raster order; `win_0` = top-left, `win_8` = bottom-right
- `win_valid`  out  1  window outputs valid this cycle
- `frame_done`  out  1  one-cycle pulse with the last window of a frame

## Operation
- Column counter `col` (0..IMG_W-1) and row counter `row` (0..IMG_H-1) advance only on `pix_valid`.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_H-1, IMG_W-1), both wrap to 0. The next frame follows back-to-back with no idle cycle required.
- Two line buffers, each IMG_W deep, hold lines row-1 and row-2. A 3x3 shift register window shifts left by one column on each accepted pixel.
- A window is complete when the accepted pixel has `row >= 2` and `col >= 2`. There is no padding, so each frame produces (IMG_H-2)*(IMG_W-2) windows.
- Window element k at pixel (r,c) = pixel (r-2+k/3, c-2+k%3).
- Gating per element k:
  - `weight_q[k]=1` → value passed unchanged.
  - `weight_q[k]=0` → 0, or negation when `WEIGHT_NEG_EN` is defined (see Configuration).
- Weight register:
  - Reset value 9'h1FF.
  - Updates on `weight_load`, independently of `pix_valid`.
  - On a cycle with both `weight_load` and `pix_valid`, that pixel's window uses the OLD weights. The new weights apply from the next accepted pixel.
- Line-buffer contents are not reset. Output validity depends only on the counters, so stale data is never exposed.

## Timing
- Latency: `win_valid` asserts exactly 1 cycle after the `pix_valid` cycle that completes a window. `win_0..win_8` are registered and valid in that same cycle.
- `win_valid` is a single-cycle pulse per window. It is never asserted on a cycle without a preceding accepted pixel.
- `win_*` hold their last value when `win_valid`=0.
- `frame_done` asserts coincident with `win_valid` for the window of pixel (IMG_H-1, IMG_W-1).
- Reset values: `win_0..win_8`=0, `win_valid`=0, `frame_done`=0, `row`=`col`=0, `weight_q`=9'h1FF.
- Reset mid-frame: counters clear. The next accepted pixel is treated as (0,0). No window is emitted until pixel (2,2) of the new frame.
- `rst` takes priority over `pix_valid` and `weight_load` in the same cycle.
- Maximum throughput: one pixel per cycle.

## Configuration
- `WEIGHT_NEG_EN` defined: weight bit 0 outputs the two's-complement negation of the element (bipolar ±1 weights).
  - Negation wraps in DATA_W: -(-2048) = -2048 (12'h800).
- `WEIGHT_NEG_EN` not defined: weight bit 0 outputs 0 (unipolar 0/1 weights). The negation logic is absent.

## Structure
- Shared package `bc_pkg`:
  - `DATA_W` default, `WIN_N`=9, `WIN_SIDE`=3.
  - Window index constants (`WIN_TL`=0 … `WIN_BR`=8), also used by the neuron stage.
- Sub-module `line_buffer`: IMG_W-deep, DATA_W-wide shift register with shift enable. Instantiated twice, chained so that line row-1 feeds line row-2.
- Top module holds the counters, 3x3 window registers, weight register, gating and output registers.

## Test plan
All scenarios use IMG_W=4, IMG_H=4; pixel value = 4*row+col.
- Reset: hold `rst` 2 cycles → all `win_*`=0, `win_valid`=0, `frame_done`=0, `weight_q`=9'h1FF.
- Full frame, weights 9'h1FF, continuous `pix_valid`, 16 pixels:
  - First `win_valid` 1 cycle after pixel 10, with `win_0..8` = 0,1,2,4,5,6,8,9,10.
  - Exactly 4 windows in total.
  - Last window is 5,6,7,9,10,11,13,14,15, with `frame_done`=1 in the same cycle.
- Weights 9'h101 loaded, then full frame:
  - First window: `win_0`=0, `win_8`=10, all others 0.
  - With `WEIGHT_NEG_EN`: others are negated, e.g. `win_1`=12'hFFF and `win_4`=12'hFFB.
- `pix_valid` toggled 1-0-1-0 over the whole frame → identical window values and count as the continuous case; each `win_valid` 1 cycle after its completing pixel.
- `rst` after 6 pixels, then a full frame → no `win_valid` before the new frame's pixel 10; windows are identical to the continuous case.
- `WEIGHT_NEG_EN`, weights 9'h000, all pixels 12'h19A → every `win_k`=12'hE66. Two back-to-back frames give 8 windows and 2 `frame_done` pulses.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared constants for the binary-weight conv path: default pixel width, window geometry
// and window element indices, used by the window generator and the neuron stage.
// No logic and no latency; constants only.
package bc_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int WIN_SIDE   = 3;
    localparam int WIN_N      = WIN_SIDE * WIN_SIDE;

    // Raster order inside the 3x3 window: top row first, left to right.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: DEPTH-deep shift register advanced only when en is high.
// Latency: dout is the sample accepted DEPTH enables ago; combinational read of the tail.
// No backpressure; storage is deliberately not reset.
module line_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 28
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator with binary-weight gating (macro WEIGHT_NEG_EN: 0-weights negate).
// Latency: window registered 1 cycle after the pixel that completes it; frame_done rides the last one.
// No backpressure: every pix_valid is consumed, at most one pixel per cycle.
module conv_window_gen #(
    parameter int DATA_W = bc_pkg::DEF_DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic [8:0]        weight_in,
    input  logic              weight_load,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic              win_valid,
    output logic              frame_done
);

    import bc_pkg::*;

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [8:0]        weight_q;
    logic [DATA_W-1:0] lb1_out;
    logic [DATA_W-1:0] lb2_out;
    logic [DATA_W-1:0] win_sr  [WIN_SIDE][WIN_SIDE];
    logic [DATA_W-1:0] win_nxt [WIN_SIDE][WIN_SIDE];
    logic [DATA_W-1:0] gated   [WIN_N];
    logic [DATA_W-1:0] win_q   [WIN_N];
    logic              shift_en;
    logic              col_last;
    logic              row_last;
    logic              win_done;

    function automatic logic [DATA_W-1:0] gate(input logic [DATA_W-1:0] v, input logic w);
`ifdef WEIGHT_NEG_EN
        return w ? v : -v;
`else
        return w ? v : '0;
`endif
    endfunction

    assign shift_en = pix_valid && !rst;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign win_done = (row >= RW'(2)) && (col >= CW'(2));

    // lb1 delivers line row-1 and feeds lb2, which delivers line row-2.
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .en   (shift_en),
        .din  (pix_in),
        .dout (lb1_out)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
        .clk  (clk),
        .en   (shift_en),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Window as it stands after this pixel's shift, so the output needs only one register stage.
    always_comb begin
        for (int i = 0; i < WIN_SIDE; i++) begin
            for (int j = 0; j < WIN_SIDE - 1; j++) begin
                win_nxt[i][j] = win_sr[i][j+1];
            end
        end
        win_nxt[0][WIN_SIDE-1] = lb2_out;
        win_nxt[1][WIN_SIDE-1] = lb1_out;
        win_nxt[2][WIN_SIDE-1] = pix_in;
        for (int k = 0; k < WIN_N; k++) begin
            gated[k] = gate(win_nxt[k / WIN_SIDE][k % WIN_SIDE], weight_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            win_sr <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            weight_q   <= 9'h1FF;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k < WIN_N; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            win_valid  <= pix_valid && win_done;
            frame_done <= pix_valid && win_done && row_last && col_last;
            // gated[] above already used the old weight_q, so a coincident load affects the next pixel.
            if (weight_load) begin
                weight_q <= weight_in;
            end
            if (pix_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (win_done) begin
                    win_q <= gated;
                end
            end
        end
    end

    assign win_0 = win_q[WIN_TL];
    assign win_1 = win_q[WIN_TC];
    assign win_2 = win_q[WIN_TR];
    assign win_3 = win_q[WIN_ML];
    assign win_4 = win_q[WIN_MC];
    assign win_5 = win_q[WIN_MR];
    assign win_6 = win_q[WIN_BL];
    assign win_7 = win_q[WIN_BC];
    assign win_8 = win_q[WIN_BR];

endmodule
